// File: rtl/dimmer_ctrl_if.sv
// Button inputs and brightness outputs shared between the dimmer and its user.
interface dimmer_ctrl_if;
  localparam int unsigned DUTY_W = 19;
  localparam int unsigned LVL_W  = 4;

  logic              btn_up;
  logic              btn_down;
  logic              btn_mode;
  logic [DUTY_W-1:0] duty;
  logic [LVL_W-1:0]  level;
  logic              auto_mode;
  logic              frame_tick;

  modport master (
    output btn_up, btn_down, btn_mode,
    input  duty, level, auto_mode, frame_tick
  );

  modport slave (
    input  btn_up, btn_down, btn_mode,
    output duty, level, auto_mode, frame_tick
  );
endinterface

// File: rtl/dimmer_ctrl.sv
// Brightness sequencer: debounced buttons step or auto-fade a level that is
// applied to the PWM duty only at frame boundaries.
module dimmer_ctrl #(
  parameter int unsigned PERIOD      = 500000,
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned NUM_LEVELS  = 10,
  parameter int unsigned STEP        = 50000,
  parameter int unsigned FADE_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dimmer_ctrl_if.slave bus
);

  localparam int unsigned DUTY_W = 19;
  localparam int unsigned LVL_W  = 4;
  localparam int unsigned NBTN   = 3;
  localparam int unsigned CNT_W  = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned FADE_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } state_t;

  // Button index order: 0 = up, 1 = down, 2 = mode
  logic [NBTN-1:0]  w_raw;
  logic [NBTN-1:0]  r_sync1;
  logic [NBTN-1:0]  r_sync2;
  logic [NBTN-1:0]  r_deb;
  logic [NBTN-1:0]  r_press;
  logic [DEB_W-1:0] r_dcnt [NBTN];

  logic [CNT_W-1:0]  r_fcount;
  logic              r_frame_tick;
  logic [DUTY_W-1:0] r_duty;

  state_t            r_state, w_state_nxt;
  logic [LVL_W-1:0]  r_level, w_level_nxt;
  logic [FADE_W-1:0] r_fade_cnt, w_fade_cnt_nxt;
  logic              r_auto, w_auto_nxt;
  logic              w_up_ev, w_down_ev, w_mode_ev;
  logic              w_fade_step;

  assign w_raw     = {bus.btn_mode, bus.btn_down, bus.btn_up};
  assign w_up_ev   = r_press[0];
  assign w_down_ev = r_press[1];
  assign w_mode_ev = r_press[2];

  // Synchronize, debounce and edge-detect each button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      for (int i = 0; i < NBTN; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NBTN; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] != r_deb[i]) begin
          if (r_dcnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
            r_deb[i]   <= r_sync2[i];
            r_dcnt[i]  <= '0;
            r_press[i] <= r_sync2[i];
          end else begin
            r_dcnt[i] <= r_dcnt[i] + DEB_W'(1);
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  // Frame counter; tick is registered so it is high while the count equals PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcount     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      if (r_fcount == CNT_W'(PERIOD)) r_fcount <= '0;
      else                            r_fcount <= r_fcount + CNT_W'(1);
      r_frame_tick <= (r_fcount == CNT_W'(PERIOD - 1));
    end
  end

  // Duty takes the pre-update level on the last clock of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_duty <= '0;
    else if (r_frame_tick) r_duty <= DUTY_W'(32'(r_level) * STEP);
  end

  // FSM and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MANUAL;
      r_level    <= '0;
      r_fade_cnt <= '0;
      r_auto     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_fade_cnt <= w_fade_cnt_nxt;
      r_auto     <= w_auto_nxt;
    end
  end

  assign w_fade_step = r_frame_tick && (r_fade_cnt == FADE_W'(FADE_FRAMES - 1));

  // Next-state and level logic; mode events take priority over fade steps
  always_comb begin
    w_state_nxt    = r_state;
    w_level_nxt    = r_level;
    w_fade_cnt_nxt = r_fade_cnt;
    w_auto_nxt     = r_auto;
    case (r_state)
      MANUAL: begin
        if (w_mode_ev) begin
          w_auto_nxt     = 1'b1;
          w_fade_cnt_nxt = '0;
          w_state_nxt    = (r_level == LVL_W'(NUM_LEVELS)) ? FADE_DOWN : FADE_UP;
        end else if (w_up_ev && !w_down_ev) begin
          if (r_level < LVL_W'(NUM_LEVELS)) w_level_nxt = r_level + LVL_W'(1);
        end else if (w_down_ev && !w_up_ev) begin
          if (r_level != '0) w_level_nxt = r_level - LVL_W'(1);
        end
      end
      FADE_UP, FADE_DOWN: begin
        if (w_mode_ev) begin
          w_auto_nxt     = 1'b0;
          w_fade_cnt_nxt = '0;
          w_state_nxt    = MANUAL;
        end else if (w_fade_step) begin
          w_fade_cnt_nxt = '0;
          if (r_state == FADE_UP) begin
            if (r_level < LVL_W'(NUM_LEVELS)) w_level_nxt = r_level + LVL_W'(1);
            if (r_level >= LVL_W'(NUM_LEVELS - 1)) w_state_nxt = FADE_DOWN;
          end else begin
            if (r_level != '0) w_level_nxt = r_level - LVL_W'(1);
            if (r_level <= LVL_W'(1)) w_state_nxt = FADE_UP;
          end
        end else if (r_frame_tick) begin
          w_fade_cnt_nxt = r_fade_cnt + FADE_W'(1);
        end
      end
      default: begin
        w_state_nxt    = MANUAL;
        w_auto_nxt     = 1'b0;
        w_fade_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.duty       = r_duty;
  assign bus.level      = r_level;
  assign bus.auto_mode  = r_auto;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_dimmer_ctrl.sv
// Directed bench for dimmer_ctrl using reduced timing parameters.
module tb_dimmer_ctrl;
  localparam int unsigned PERIOD      = 99;
  localparam int unsigned DEB_CYCLES  = 8;
  localparam int unsigned NUM_LEVELS  = 4;
  localparam int unsigned STEP        = 25;
  localparam int unsigned FADE_FRAMES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dimmer_ctrl_if dif ();

  dimmer_ctrl #(
    .PERIOD(PERIOD), .DEB_CYCLES(DEB_CYCLES), .NUM_LEVELS(NUM_LEVELS),
    .STEP(STEP), .FADE_FRAMES(FADE_FRAMES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(dif)
  );

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stop in the clock where frame_tick is high (bounded)
  task automatic wait_tick();
    int k = 0;
    while (dif.frame_tick !== 1'b1 && k < 2 * (PERIOD + 1)) begin
      cyc(1);
      k++;
    end
    if (dif.frame_tick !== 1'b1) chk("tick_timeout", 0, 1);
  endtask

  // Advance to count 0 of the next frame
  task automatic next_frame();
    wait_tick();
    cyc(1);
  endtask

  // m = {mode, down, up}: clean 20-clock press then 20-clock release
  task automatic press(input logic [2:0] m);
    dif.btn_up   = m[0];
    dif.btn_down = m[1];
    dif.btn_mode = m[2];
    cyc(20);
    dif.btn_up   = 1'b0;
    dif.btn_down = 1'b0;
    dif.btn_mode = 1'b0;
    cyc(20);
  endtask

  int ticks;
  logic [3:0] fade_seq [7];

  initial begin
    fade_seq[0] = 4'd3; fade_seq[1] = 4'd4; fade_seq[2] = 4'd3; fade_seq[3] = 4'd2;
    fade_seq[4] = 4'd1; fade_seq[5] = 4'd0; fade_seq[6] = 4'd1;
    dif.btn_up   = 1'b0;
    dif.btn_down = 1'b0;
    dif.btn_mode = 1'b0;

    // Reset and frame timing
    cyc(5);
    chk("rst_duty", 32'(dif.duty), 0);
    chk("rst_level", 32'(dif.level), 0);
    chk("rst_auto", 32'(dif.auto_mode), 0);
    chk("rst_tick", 32'(dif.frame_tick), 0);
    rst_n = 1'b1;
    ticks = 0;
    for (int k = 1; k <= 300; k++) begin
      cyc(1);
      if (dif.frame_tick === 1'b1) ticks++;
      if (k == 99 || k == 199 || k == 299) chk("tick_at_last", 32'(dif.frame_tick), 1);
      if (k == 100 || k == 98) chk("tick_off", 32'(dif.frame_tick), 0);
    end
    chk("tick_count", 32'(ticks), 3);
    chk("idle_level", 32'(dif.level), 0);

    // Debounce: glitch ignored, clean press counted once
    dif.btn_up = 1'b1;
    cyc(5);
    dif.btn_up = 1'b0;
    cyc(20);
    chk("glitch_level", 32'(dif.level), 0);
    press(3'b001);
    chk("press_level", 32'(dif.level), 1);
    cyc(10);
    chk("press_once", 32'(dif.level), 1);
    wait_tick();
    chk("duty_hold", 32'(dif.duty), 0);
    cyc(1);
    chk("duty_lvl1", 32'(dif.duty), 25);

    // Saturation both ways and simultaneous up/down
    for (int i = 0; i < 6; i++) press(3'b001);
    chk("sat_hi_level", 32'(dif.level), 4);
    next_frame();
    chk("sat_hi_duty", 32'(dif.duty), 100);
    for (int i = 0; i < 6; i++) press(3'b010);
    chk("sat_lo_level", 32'(dif.level), 0);
    next_frame();
    chk("sat_lo_duty", 32'(dif.duty), 0);
    press(3'b001);
    press(3'b011);
    chk("updown_level", 32'(dif.level), 1);
    press(3'b001);
    chk("pre_fade_level", 32'(dif.level), 2);

    // Auto fade from level 2 with up presses ignored
    next_frame();
    press(3'b100);
    chk("fade_auto", 32'(dif.auto_mode), 1);
    chk("fade_start_level", 32'(dif.level), 2);
    for (int i = 0; i < 7; i++) begin
      next_frame();
      if (i == 1 || i == 4) press(3'b001);
      chk("fade_mid_level", 32'(dif.level), (i == 0) ? 32'd2 : 32'(fade_seq[i-1]));
      next_frame();
      chk("fade_level", 32'(dif.level), 32'(fade_seq[i]));
    end

    // Exit auto at level 3
    next_frame();
    next_frame();
    next_frame();
    next_frame();
    chk("exit_pre_level", 32'(dif.level), 3);
    press(3'b100);
    chk("exit_auto", 32'(dif.auto_mode), 0);
    chk("exit_level", 32'(dif.level), 3);
    next_frame();
    chk("exit_duty", 32'(dif.duty), 75);
    next_frame();
    next_frame();
    chk("exit_hold", 32'(dif.level), 3);
    press(3'b010);
    chk("exit_down", 32'(dif.level), 2);

    // Reset in the middle of an auto fade
    next_frame();
    press(3'b100);
    for (int i = 0; i < 5; i++) next_frame();
    chk("pre_rst_level", 32'(dif.level), 4);
    chk("pre_rst_duty", 32'(dif.duty), 100);
    chk("pre_rst_auto", 32'(dif.auto_mode), 1);
    cyc(50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_duty", 32'(dif.duty), 0);
    chk("mid_rst_level", 32'(dif.level), 0);
    chk("mid_rst_auto", 32'(dif.auto_mode), 0);
    chk("mid_rst_tick", 32'(dif.frame_tick), 0);
    cyc(3);
    rst_n = 1'b1;
    next_frame();
    next_frame();
    next_frame();
    chk("post_rst_auto", 32'(dif.auto_mode), 0);
    chk("post_rst_level", 32'(dif.level), 0);
    press(3'b001);
    chk("post_rst_manual", 32'(dif.level), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dimmer_ctrl.md
Name: dimmer_ctrl

Overview:
Brightness sequencer that drives the 19-bit duty (compare) input of the LED PWM generator. It debounces three push-buttons (up, down, mode) and keeps a brightness level. In manual mode the buttons step the level; in auto mode the block fades the level up and down continuously. The duty output changes only at PWM frame boundaries, so every PWM period runs with one duty value.

Parameters:
PERIOD, 500000, terminal count of PWM frame counter; one frame = PERIOD+1 clocks (counts 0..PERIOD inclusive)
DEB_CYCLES, 1000000, clocks a raw button level must be stable before it is accepted (20 ms at 50 MHz)
NUM_LEVELS, 10, maximum brightness level; levels run 0..NUM_LEVELS
STEP, 50000, duty increment per level; NUM_LEVELS*STEP must be <= PERIOD
FADE_FRAMES, 4, frames per level step in auto mode

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
btn_up  input  1  raw button, active-high, asynchronous to clk
btn_down  input  1  raw button, active-high, asynchronous to clk
btn_mode  input  1  raw button, active-high, toggles auto/manual
duty  output  19  compare value to PWM generator (registered)
level  output  4  current brightness level (registered)
auto_mode  output  1  1 = auto fade active (registered)
frame_tick  output  1  one-clock pulse on the last clock of each frame

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0: duty=0, level=0, auto_mode=0, frame_tick=0, FSM=MANUAL, all counters=0, synchronizers=0, debounced states=0. Assertion mid-frame or mid-debounce clears all state immediately. After release, the frame counter starts from 0.
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Debounce counter counts while the synchronized level differs from the debounced state. It clears whenever the two agree.
  - When the counter reaches DEB_CYCLES-1, the debounced state takes the new level and the counter clears.
  - Press event = 1-clock pulse on the debounced 0->1 transition. Releases generate no event.
- Frame counter:
  - Counts 0..PERIOD, then wraps to 0.
  - frame_tick=1 exactly when the count = PERIOD.
- FSM states: MANUAL, FADE_UP, FADE_DOWN.
  - MANUAL:
    - up event: level+1, saturating at NUM_LEVELS.
    - down event: level-1, saturating at 0.
    - up and down events in the same clock: level unchanged.
    - mode event: go to FADE_UP (or FADE_DOWN if level=NUM_LEVELS) and set auto_mode=1. The fade-frame counter clears.
  - FADE_UP / FADE_DOWN:
    - up and down events are ignored.
    - A fade-frame counter advances on each frame_tick. On the FADE_FRAMES-th tick, level moves one step and the counter clears.
    - FADE_UP reaching NUM_LEVELS goes to FADE_DOWN. FADE_DOWN reaching 0 goes to FADE_UP. The direction change takes effect from the next step, with no extra hold.
    - mode event: go to MANUAL with auto_mode=0. level holds its current value.
  - A mode event in the same clock as a fade step: the mode event wins and no step occurs.
- Duty update:
  - On a clock with frame_tick=1, duty <= level*STEP, where level is the value before any same-cycle level update. This makes the new duty visible from count 0 of the next frame.
  - At all other times duty holds.
  - level changes are therefore reflected in duty at the next frame boundary: latency between 1 and PERIOD+1 clocks.
- Arithmetic: the product uses an unsigned multiply truncated to 19 bits. The parameter rule guarantees no overflow. The level register is wide enough for NUM_LEVELS, 4 bits with the defaults.

Test Plan:
Simulation parameters: PERIOD=99, DEB_CYCLES=8, NUM_LEVELS=4, STEP=25, FADE_FRAMES=2.
1. Reset and frame timing: hold rst_n=0 for 5 clocks, then release -> duty=0, level=0, auto_mode=0; frame_tick pulses on clocks 99, 199, 299 after release, one clock wide.
2. Debounce: btn_up glitches high for 5 clocks, then a clean 20-clock press -> glitch ignored; level=1 once only; duty=25 from the first frame start after the event.
3. Saturation: 6 clean up presses -> level stops at 4, duty=100. Then 6 down presses -> level=0, duty=0. Up and down events in the same clock -> level unchanged.
4. Auto fade: mode press at level=2 -> auto_mode=1, FADE_UP. Level sequence 3,4,3,2,1,0,1, each step on every 2nd frame_tick. up presses during the fade -> no effect.
5. Exit auto: mode press while level=3 -> auto_mode=0, level stays 3, duty=75 at the next frame; a following down press gives level=2.
6. Reset mid-operation: assert rst_n during auto fade at frame count 50 -> all outputs 0 within the same clock; FSM=MANUAL after release.
